// File: rtl/au_pkg.sv
// Shared constants for the saturating arithmetic unit.
package au_pkg;

  localparam logic [1:0] CMD_ADD    = 2'b00;
  localparam logic [1:0] CMD_SUB    = 2'b01;
  localparam logic [1:0] CMD_PADDSB = 2'b10;

  localparam logic [15:0] SAT16_POS = 16'h7FFF;
  localparam logic [15:0] SAT16_NEG = 16'h8000;
  localparam logic [7:0]  SAT8_POS  = 8'h7F;
  localparam logic [7:0]  SAT8_NEG  = 8'h80;

endpackage

// File: rtl/sat_adder.sv
// W-bit signed saturating adder with carry-in; reports raw carry-out and
// signed overflow alongside the clamped sum.
module sat_adder #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  logic [W:0] raw;

  assign raw  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
  assign cout = raw[W];
  assign ovf  = (x[W-1] == y[W-1]) && (raw[W-1] != x[W-1]);

  // Overflow direction follows the operands' common sign.
  always_comb begin
    sum = raw[W-1:0];
    if (ovf) begin
      sum = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/arith_unit.sv
// Execute-stage saturating ALU: ADD, SUB and paired-byte PADDSB with
// registered result and carry/overflow/negative flags (1-cycle latency).
module arith_unit
  import au_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cmd,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        cout,
  output logic        v,
  output logic        n
);

  logic        is_sub;
  logic [15:0] y16;
  logic [15:0] sum16;
  logic        c16, o16;
  logic [7:0]  sum_hi, sum_lo;
  logic        c_hi, o_hi, c_lo, o_lo;

  logic [15:0] result_d, result_q;
  logic        cout_d, cout_q;
  logic        v_d, v_q;

  // SUB reuses the adder as a + ~b + 1.
  assign is_sub = (cmd == CMD_SUB);
  assign y16    = is_sub ? ~b : b;

  sat_adder #(.W(16)) u_add16 (
    .x    (a),
    .y    (y16),
    .cin  (is_sub),
    .sum  (sum16),
    .cout (c16),
    .ovf  (o16)
  );

  sat_adder #(.W(8)) u_add_hi (
    .x    (a[15:8]),
    .y    (b[15:8]),
    .cin  (1'b0),
    .sum  (sum_hi),
    .cout (c_hi),
    .ovf  (o_hi)
  );

  sat_adder #(.W(8)) u_add_lo (
    .x    (a[7:0]),
    .y    (b[7:0]),
    .cin  (1'b0),
    .sum  (sum_lo),
    .cout (c_lo),
    .ovf  (o_lo)
  );

  // Low-lane carry is intentionally dropped: lanes are independent.
  always_comb begin
    result_d = sum16;
    cout_d   = c16;
    v_d      = o16;
    if (cmd[1]) begin
      result_d = {sum_hi, sum_lo};
      cout_d   = c_hi;
      v_d      = o_hi | o_lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      cout_q   <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
      v_q      <= v_d;
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign v      = v_q;
  assign n      = result_q[15];

  logic unused_c_lo;
  assign unused_c_lo = c_lo;

endmodule

// File: tb/tb_arith_unit.sv
// Bench for arith_unit: directed vector table, reset/latency sequences and
// randomized back-to-back traffic against an integer-arithmetic model.
module tb_arith_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd;
  logic [15:0] a, b;
  logic [15:0] result;
  logic        cout, v, n;

  int n_cmp = 0;
  int n_bad = 0;

  arith_unit dut (
    .clk    (clk),
    .rst    (rst),
    .cmd    (cmd),
    .a      (a),
    .b      (b),
    .result (result),
    .cout   (cout),
    .v      (v),
    .n      (n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        n;
  } vec_t;

  vec_t vecs[17];

  // Reference: signed integer sums with explicit clamping; carry from
  // unsigned magnitude comparison.
  function automatic logic [18:0] model(input logic [1:0] c, input logic [15:0] x,
                                        input logic [15:0] y);
    int sx, sy, s, ux, uy;
    logic [15:0] r;
    logic co, ov;
    if (c[1]) begin
      logic [7:0] xh, yh, xl, yl, rh, rl;
      int ph, pl, hx, hy, lx, ly;
      logic oh, ol;
      xh = x[15:8]; yh = y[15:8]; xl = x[7:0]; yl = y[7:0];
      hx = $signed(xh); hy = $signed(yh); lx = $signed(xl); ly = $signed(yl);
      ph = hx + hy; pl = lx + ly;
      oh = (ph > 127) || (ph < -128);
      ol = (pl > 127) || (pl < -128);
      rh = (ph > 127) ? 8'h7F : (ph < -128) ? 8'h80 : 8'(ph);
      rl = (pl > 127) ? 8'h7F : (pl < -128) ? 8'h80 : 8'(pl);
      ux = xh; uy = yh;
      co = (ux + uy) > 255;
      ov = oh | ol;
      r  = {rh, rl};
    end else begin
      sx = $signed(x); sy = $signed(y);
      ux = x; uy = y;
      s  = c[0] ? (sx - sy) : (sx + sy);
      co = c[0] ? (ux >= uy) : ((ux + uy) > 65535);
      ov = (s > 32767) || (s < -32768);
      r  = (s > 32767) ? 16'h7FFF : (s < -32768) ? 16'h8000 : 16'(s);
    end
    return {r, co, ov, r[15]};
  endfunction

  task automatic check(input string name, input logic [18:0] exp);
    logic [18:0] got;
    got = {result, cout, v, n};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got result=%h cout=%b v=%b n=%b, expected result=%h cout=%b v=%b n=%b",
               name, got[18:3], got[2], got[1], got[0], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic [1:0] c, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    cmd = c; a = x; b = y;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [18:0] prev, exp;

    vecs[0]  = '{2'b00, 16'h8000, 16'h80F0, 16'h8000, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{2'b00, 16'hF00F, 16'hFFF0, 16'hEFFF, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{2'b00, 16'h700F, 16'h7FF0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{2'b01, 16'h70F0, 16'h2000, 16'h50F0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{2'b01, 16'h2000, 16'h70F0, 16'hAF10, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{2'b01, 16'hFF00, 16'h10F0, 16'hEE10, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{2'b01, 16'h10F0, 16'hFF00, 16'h11F0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'b01, 16'hFF00, 16'h800F, 16'h7EF1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{2'b01, 16'h10F0, 16'h8F00, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{2'b01, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{2'b01, 16'h0000, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{2'b10, 16'h7F01, 16'h0101, 16'h7F02, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{2'b10, 16'h80FF, 16'hFF01, 16'h8000, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{2'b10, 16'h1020, 16'h0102, 16'h1122, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{2'b11, 16'h7F01, 16'h0101, 16'h7F02, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{2'b11, 16'h80FF, 16'hFF01, 16'h8000, 1'b1, 1'b1, 1'b1};
    vecs[16] = '{2'b11, 16'h1020, 16'h0102, 16'h1122, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; cmd = 2'b00; a = 16'h1234; b = 16'h1111;
    #1;
    check("reset_state", '0);
    @(posedge clk); #1;
    check("reset_held_over_edge", '0);

    // Release with an op already applied; it must load on the next edge.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("first_after_reset", {16'h2345, 1'b0, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      drive(vecs[i].cmd, vecs[i].a, vecs[i].b);
      @(posedge clk); #1;
      check($sformatf("vec%0d_%h_%h_%h", i, vecs[i].cmd, vecs[i].a, vecs[i].b),
            {vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].n});
    end

    // Latency: new inputs must not reach the outputs before the edge.
    prev = {vecs[16].res, vecs[16].c, vecs[16].v, vecs[16].n};
    drive(2'b00, 16'h8000, 16'h80F0);
    #1;
    check("latency_hold_before_edge", prev);
    @(posedge clk); #1;
    check("latency_load_after_edge", {16'h8000, 1'b1, 1'b1, 1'b1});

    // Asynchronous reset mid-cycle with nonzero outputs, in-flight op discarded.
    drive(2'b01, 16'h8000, 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_midcycle", '0);
    @(posedge clk); #1;
    check("async_reset_discards", '0);
    @(negedge clk);
    rst = 1'b0;
    cmd = 2'b10; a = 16'h1020; b = 16'h0102;
    @(posedge clk); #1;
    check("after_async_release", {16'h1122, 1'b0, 1'b0, 1'b0});

    // Back-to-back hand sequence: cmd and operands change every cycle.
    drive(2'b00, 16'h700F, 16'h7FF0);
    @(posedge clk); #1; check("b2b_0_add", {16'h7FFF, 1'b0, 1'b1, 1'b0});
    drive(2'b01, 16'h2000, 16'h70F0);
    @(posedge clk); #1; check("b2b_1_sub", {16'hAF10, 1'b0, 1'b0, 1'b1});
    drive(2'b11, 16'h80FF, 16'hFF01);
    @(posedge clk); #1; check("b2b_2_paddsb", {16'h8000, 1'b1, 1'b1, 1'b1});
    drive(2'b00, 16'hF00F, 16'hFFF0);
    @(posedge clk); #1; check("b2b_3_add", {16'hEFFF, 1'b1, 1'b0, 1'b1});

    // Randomized back-to-back traffic; bias some operands toward boundaries.
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  rc;
      logic [15:0] ra, rb;
      rc = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ((i % 8) == 3) rb = 16'h8000;
      if ((i % 8) == 5) ra = 16'h7FFF;
      if ((i % 8) == 6) ra = 16'h7F80;
      exp = model(rc, ra, rb);
      drive(rc, ra, rb);
      @(posedge clk); #1;
      check($sformatf("rand%0d_%h_%h_%h", i, rc, ra, rb), exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
